// File: rtl/euler_step_sequencer.sv
// rtl/euler_step_sequencer.sv - start/step sequencer for the Euler solver datapath
module euler_step_sequencer #(
    parameter int STEP_W    = 16,
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 0
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic              rst_sync,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              step_done,
    output logic              step_start,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
    output logic              final_done,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [STEP_W-1:0]    STEP_ONE   = STEP_W'(1);
    localparam logic [TIMEOUT_W-1:0] TIMER_ONE  = TIMEOUT_W'(1);

    state_t               state_q;
    logic                 start_q;
    logic [STEP_W-1:0]    n_q;
    logic [STEP_W-1:0]    step_idx_q;
    logic                 step_start_q;
    logic                 busy_q;
    logic                 final_done_q;
    logic                 timeout_err_q;
    logic [TIMEOUT_W-1:0] timer_q;

    logic              start_edge;
    logic [STEP_W-1:0] step_idx_d;
    logic              timer_expired;

    assign start_edge    = start & ~start_q;
    assign step_idx_d    = step_idx_q + STEP_ONE;
    assign timer_expired = (TIMEOUT > 0) && (timer_q == TIMER_LAST);

    // A single FSM process; every output is a register updated on the falling edge.
    always_ff @(negedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            n_q           <= '0;
            step_idx_q    <= '0;
            step_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            final_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else if (rst_sync) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            n_q           <= '0;
            step_idx_q    <= '0;
            step_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            final_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            start_q      <= start;
            step_start_q <= 1'b0;
            final_done_q <= 1'b0;
            if (abort) begin
                // Abort also swallows a coincident start edge; index and error are kept.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_ERR: begin
                        if (start_edge) begin
                            n_q           <= num_steps;
                            step_idx_q    <= '0;
                            timeout_err_q <= 1'b0;
                            if (num_steps == '0) begin
                                state_q      <= S_IDLE;
                                busy_q       <= 1'b0;
                                final_done_q <= 1'b1;
                            end else begin
                                state_q      <= S_ISSUE;
                                busy_q       <= 1'b1;
                                step_start_q <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        state_q <= S_WAIT;
                        timer_q <= '0;
                    end
                    S_WAIT: begin
                        timer_q <= timer_q + TIMER_ONE;
                        if (step_done) begin
                            step_idx_q <= step_idx_d;
                            if (step_idx_d == n_q) begin
                                state_q      <= S_IDLE;
                                busy_q       <= 1'b0;
                                final_done_q <= 1'b1;
                            end else begin
                                state_q      <= S_ISSUE;
                                step_start_q <= 1'b1;
                            end
                        end else if (timer_expired) begin
                            state_q       <= S_ERR;
                            busy_q        <= 1'b0;
                            timeout_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign step_start  = step_start_q;
    assign step_idx    = step_idx_q;
    assign busy        = busy_q;
    assign final_done  = final_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_euler_step_sequencer.sv
// tb/tb_euler_step_sequencer.sv - directed self-checking bench for euler_step_sequencer
module tb_euler_step_sequencer;

    localparam int STEP_W = 16;

    logic              clk = 1'b0;
    logic              rst_async = 1'b1;
    logic              rst_sync = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [STEP_W-1:0] num_steps = '0;
    logic              step_done = 1'b0;
    logic              step_start;
    logic [STEP_W-1:0] step_idx;
    logic              busy;
    logic              final_done;
    logic              timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ss_cnt   = 0;
    int fd_cnt   = 0;
    int ss_base;
    int fd_base;

    euler_step_sequencer #(
        .STEP_W   (STEP_W),
        .TIMEOUT_W(16),
        .TIMEOUT  (8)
    ) dut (
        .clk        (clk),
        .rst_async  (rst_async),
        .rst_sync   (rst_sync),
        .start      (start),
        .abort      (abort),
        .num_steps  (num_steps),
        .step_done  (step_done),
        .step_start (step_start),
        .step_idx   (step_idx),
        .busy       (busy),
        .final_done (final_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the edge opposite to the DUT's update edge.
    always @(posedge clk) begin
        if (step_start === 1'b1) ss_cnt++;
        if (final_done === 1'b1) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_step_start", 32'(step_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_final_done", 32'(final_done), 0);
        chk("rst_err", 32'(timeout_err), 0);
        chk("rst_idx", 32'(step_idx), 0);
        step();
        step();
        rst_async = 1'b0;
        step();

        // Test 1: n=3, three steps with step_done two cycles after each step_start
        num_steps = 16'd3;
        start = 1'b1;
        step();
        chk("t1_launch_ss", 32'(step_start), 1);
        chk("t1_launch_busy", 32'(busy), 1);
        chk("t1_launch_idx", 32'(step_idx), 0);
        num_steps = 16'd9;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t1_wait_ss", 32'(step_start), 0);
            step();
            step_done = 1'b1;
            step();
            step_done = 1'b0;
            chk("t1_idx", 32'(step_idx), 32'(k));
            if (k < 3) begin
                chk("t1_next_ss", 32'(step_start), 1);
                chk("t1_busy", 32'(busy), 1);
            end else begin
                chk("t1_final", 32'(final_done), 1);
                chk("t1_end_busy", 32'(busy), 0);
                chk("t1_end_ss", 32'(step_start), 0);
            end
        end
        step();
        chk("t1_final_pulse_end", 32'(final_done), 0);
        start = 1'b0;
        step();

        // Test 2: start held high for 20 cycles, n=1, datapath always done
        ss_base = ss_cnt;
        fd_base = fd_cnt;
        num_steps = 16'd1;
        start = 1'b1;
        step_done = 1'b1;
        repeat (20) step();
        chk("t2_ss_count", 32'(ss_cnt - ss_base), 1);
        chk("t2_fd_count", 32'(fd_cnt - fd_base), 1);
        chk("t2_idx", 32'(step_idx), 1);
        chk("t2_busy", 32'(busy), 0);
        start = 1'b0;
        step_done = 1'b0;
        step();

        // Test 3: n=0 gives a lone final_done
        ss_base = ss_cnt;
        num_steps = 16'd0;
        start = 1'b1;
        step();
        chk("t3_final", 32'(final_done), 1);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_ss", 32'(step_start), 0);
        chk("t3_idx", 32'(step_idx), 0);
        step();
        chk("t3_final_end", 32'(final_done), 0);
        chk("t3_ss_count", 32'(ss_cnt - ss_base), 0);
        start = 1'b0;
        step();

        // Test 4: watchdog expires after 8 cycles in WAIT
        num_steps = 16'd2;
        start = 1'b1;
        step();
        chk("t4_issue", 32'(step_start), 1);
        step();
        repeat (7) step();
        chk("t4_pre_err", 32'(timeout_err), 0);
        chk("t4_pre_busy", 32'(busy), 1);
        step();
        chk("t4_err", 32'(timeout_err), 1);
        chk("t4_err_busy", 32'(busy), 0);
        chk("t4_err_idx", 32'(step_idx), 0);
        repeat (3) step();
        chk("t4_err_sticky", 32'(timeout_err), 1);
        start = 1'b0;
        step();
        num_steps = 16'd1;
        start = 1'b1;
        step();
        chk("t4_relaunch_err", 32'(timeout_err), 0);
        chk("t4_relaunch_ss", 32'(step_start), 1);
        chk("t4_relaunch_busy", 32'(busy), 1);
        step();
        step_done = 1'b1;
        step();
        step_done = 1'b0;
        chk("t4_relaunch_final", 32'(final_done), 1);
        start = 1'b0;
        step();

        // Test 5: abort after the second step_done, then abort with a start edge
        num_steps = 16'd5;
        start = 1'b1;
        step();
        for (int k = 1; k <= 2; k++) begin
            step();
            step_done = 1'b1;
            step();
            step_done = 1'b0;
        end
        chk("t5_pre_abort_idx", 32'(step_idx), 2);
        fd_base = fd_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_busy", 32'(busy), 0);
        chk("t5_abort_ss", 32'(step_start), 0);
        chk("t5_abort_idx", 32'(step_idx), 2);
        step_done = 1'b1;
        repeat (3) step();
        step_done = 1'b0;
        chk("t5_no_final", 32'(fd_cnt - fd_base), 0);
        chk("t5_idx_kept", 32'(step_idx), 2);
        start = 1'b0;
        step();
        start = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_start_busy", 32'(busy), 0);
        chk("t5_abort_start_ss", 32'(step_start), 0);
        step();
        chk("t5_no_late_launch", 32'(busy), 0);
        start = 1'b0;
        step();

        // Test 6: asynchronous reset between edges mid-WAIT
        num_steps = 16'd3;
        start = 1'b1;
        step();
        step();
        step_done = 1'b1;
        step();
        step_done = 1'b0;
        step();
        chk("t6_pre_busy", 32'(busy), 1);
        chk("t6_pre_idx", 32'(step_idx), 1);
        #2;
        rst_async = 1'b1;
        start = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_idx", 32'(step_idx), 0);
        chk("t6_rst_ss", 32'(step_start), 0);
        chk("t6_rst_final", 32'(final_done), 0);
        step_done = 1'b1;
        step();
        rst_async = 1'b0;
        step();
        step_done = 1'b0;
        chk("t6_idle_done_idx", 32'(step_idx), 0);
        chk("t6_idle_done_busy", 32'(busy), 0);
        chk("t6_idle_done_final", 32'(final_done), 0);

        // Synchronous reset mid-run
        num_steps = 16'd2;
        start = 1'b1;
        step();
        chk("t7_launch_busy", 32'(busy), 1);
        rst_sync = 1'b1;
        step();
        rst_sync = 1'b0;
        start = 1'b0;
        chk("t7_srst_busy", 32'(busy), 0);
        chk("t7_srst_ss", 32'(step_start), 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
